// File: rtl/mult_div_unit_if.sv
// Handshake bundle between the E-stage decode/forwarding logic and the
// multiply/divide unit: command codes and operands in, busy flag and HI/LO out.
interface mult_div_unit_if;
   logic [2:0]  start;
   logic [1:0]  MD;
   logic        req;
   logic [31:0] A;
   logic [31:0] B;
   logic        busy;
   logic [31:0] HI;
   logic [31:0] LO;

   modport master (output start, MD, req, A, B, input busy, HI, LO);
   modport slave  (input start, MD, req, A, B, output busy, HI, LO);
endinterface

// File: rtl/mult_div_unit.sv
// Execute-stage multiply/divide unit owning HI/LO. The result is computed at accept,
// parked in pend_*, and committed after a fixed latency modelled by a down-counter.
module mult_div_unit #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic            clk,
   input  logic            reset,
   mult_div_unit_if.slave  bus
);
   localparam logic [3:0] LP_MULT_CNT = 4'(MULT_CYCLES);
   localparam logic [3:0] LP_DIV_CNT  = 4'(DIV_CYCLES);

   logic [3:0]  r_cnt;
   logic [31:0] r_pend_hi;
   logic [31:0] r_pend_lo;
   logic        r_div0;
   logic [31:0] r_hi;
   logic [31:0] r_lo;

   logic        w_busy;
   logic        w_start_op;
   logic        w_is_div;
   logic        w_accept;
   logic        w_md_ok;
   logic        w_b_zero;
   logic [63:0] w_prod_s;
   logic [63:0] w_prod_u;
   logic [31:0] w_abs_a;
   logic [31:0] w_abs_b;
   logic [31:0] w_sdiv_d;
   logic [31:0] w_q_mag;
   logic [31:0] w_r_mag;
   logic [31:0] w_q_s;
   logic [31:0] w_r_s;
   logic [31:0] w_udiv_d;
   logic [31:0] w_q_u;
   logic [31:0] w_r_u;
   logic [31:0] w_res_hi;
   logic [31:0] w_res_lo;

   assign w_busy     = (r_cnt != 4'd0);
   assign w_start_op = (bus.start >= 3'd1) && (bus.start <= 3'd4);
   assign w_is_div   = (bus.start == 3'd3) || (bus.start == 3'd4);
   assign w_accept   = !bus.req && !w_busy && w_start_op;
   assign w_md_ok    = !bus.req && !w_busy && !w_start_op;
   assign w_b_zero   = (bus.B == 32'd0);

   assign w_prod_s = {{32{bus.A[31]}}, bus.A} * {{32{bus.B[31]}}, bus.B};
   assign w_prod_u = {32'd0, bus.A} * {32'd0, bus.B};

   // Signed divide on magnitudes; 0x80000000 negates to itself, which yields the required overflow result.
   assign w_abs_a  = bus.A[31] ? (~bus.A + 32'd1) : bus.A;
   assign w_abs_b  = bus.B[31] ? (~bus.B + 32'd1) : bus.B;
   assign w_sdiv_d = w_b_zero ? 32'd1 : w_abs_b;
   assign w_q_mag  = w_abs_a / w_sdiv_d;
   assign w_r_mag  = w_abs_a % w_sdiv_d;
   assign w_q_s    = (bus.A[31] ^ bus.B[31]) ? (~w_q_mag + 32'd1) : w_q_mag;
   assign w_r_s    = bus.A[31] ? (~w_r_mag + 32'd1) : w_r_mag;

   assign w_udiv_d = w_b_zero ? 32'd1 : bus.B;
   assign w_q_u    = bus.A / w_udiv_d;
   assign w_r_u    = bus.A % w_udiv_d;

   // Select the result that will be parked for the accepted operation.
   always_comb begin
      w_res_hi = 32'd0;
      w_res_lo = 32'd0;
      case (bus.start)
         3'd1: begin
            w_res_hi = w_prod_s[63:32];
            w_res_lo = w_prod_s[31:0];
         end
         3'd2: begin
            w_res_hi = w_prod_u[63:32];
            w_res_lo = w_prod_u[31:0];
         end
         3'd3: begin
            w_res_hi = w_r_s;
            w_res_lo = w_q_s;
         end
         3'd4: begin
            w_res_hi = w_r_u;
            w_res_lo = w_q_u;
         end
         default: begin
            w_res_hi = 32'd0;
            w_res_lo = 32'd0;
         end
      endcase
   end

   // Accept, count down, commit on 1->0 (skipped for divide by zero), and mthi/mtlo when idle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt     <= 4'd0;
         r_pend_hi <= 32'd0;
         r_pend_lo <= 32'd0;
         r_div0    <= 1'b0;
         r_hi      <= 32'd0;
         r_lo      <= 32'd0;
      end else if (w_accept) begin
         r_pend_hi <= w_res_hi;
         r_pend_lo <= w_res_lo;
         r_div0    <= w_is_div && w_b_zero;
         r_cnt     <= w_is_div ? LP_DIV_CNT : LP_MULT_CNT;
      end else if (w_busy) begin
         r_cnt <= r_cnt - 4'd1;
         if ((r_cnt == 4'd1) && !r_div0) begin
            r_hi <= r_pend_hi;
            r_lo <= r_pend_lo;
         end
      end else if (w_md_ok) begin
         if (bus.MD == 2'd1) begin
            r_hi <= bus.A;
         end else if (bus.MD == 2'd3) begin
            r_lo <= bus.A;
         end
      end
   end

   assign bus.busy = w_busy;
   assign bus.HI   = r_hi;
   assign bus.LO   = r_lo;
endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes expected HI/LO and busy length
// from an arithmetic reference model; a negedge monitor checks each completion.
module tb_mult_div_unit;
   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          cycles;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   errors = 0;
   int   checks = 0;
   exp_t exp_q[$];
   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;

   mult_div_unit_if bus();

   mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] ref_res(input logic [2:0] s, input logic [31:0] a, input logic [31:0] b);
      longint          sa, sb, q, r;
      longint unsigned ua, ub, p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (s)
         3'd1: begin q = sa * sb; return 64'(q); end
         3'd2: begin p = ua * ub; return 64'(p); end
         3'd3: begin q = sa / sb; r = sa % sb; return {r[31:0], q[31:0]}; end
         3'd4: begin p = ua / ub; ua = ua % ub; return {ua[31:0], p[31:0]}; end
         default: return 64'd0;
      endcase
   endfunction

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle;
      int n = 0;
      while (bus.busy === 1'b1 && n < 40) begin
         cyc();
         n++;
      end
      if (n >= 40) chk("idle_timeout", 32'd1, 32'd0);
   endtask

   // Drive one command for one cycle from an idle DUT and record what the model expects.
   task automatic issue(input logic [2:0] s, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] md, input logic r);
      logic        acc;
      logic [63:0] res;
      exp_t        e;
      acc = !r && (s >= 3'd1) && (s <= 3'd4);
      bus.start = s; bus.MD = md; bus.req = r; bus.A = a; bus.B = b;
      if (acc) begin
         e.cycles = (s >= 3'd3) ? 10 : 5;
         if (s >= 3'd3 && b == 32'd0) begin
            e.hi = m_hi;
            e.lo = m_lo;
         end else begin
            res  = ref_res(s, a, b);
            e.hi = res[63:32];
            e.lo = res[31:0];
         end
         m_hi = e.hi;
         m_lo = e.lo;
         exp_q.push_back(e);
      end else if (!r) begin
         if (md == 2'd1) m_hi = a;
         else if (md == 2'd3) m_lo = a;
      end
      cyc();
      bus.start = 3'd0; bus.MD = 2'd0; bus.req = 1'b0;
      if (!acc) begin
         chk("hi_reg", bus.HI, m_hi);
         chk("lo_reg", bus.LO, m_lo);
      end
   endtask

   // Monitor: measures each busy run and checks HI/LO when it ends.
   initial begin
      int   run = 0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset) begin
            exp_q.delete();
            run = 0;
         end else if (bus.busy) begin
            run++;
         end else if (run > 0) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_completion", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("done_hi", bus.HI, e.hi);
               chk("done_lo", bus.LO, e.lo);
               chk("busy_cycles", 32'(run), 32'(e.cycles));
            end
            run = 0;
         end
      end
   end

   initial begin
      logic [2:0]  s;
      logic [31:0] a, b;
      bus.start = 3'd0; bus.MD = 2'd0; bus.req = 1'b0; bus.A = 32'd0; bus.B = 32'd0;
      repeat (3) cyc();
      chk("reset_busy", {31'd0, bus.busy}, 32'd0);
      chk("reset_hi", bus.HI, 32'd0);
      chk("reset_lo", bus.LO, 32'd0);
      reset = 1'b0;
      cyc();

      issue(3'd1, 32'hFFFFFFFE, 32'd3, 2'd0, 1'b0);  wait_idle();
      issue(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'd0, 1'b0);  wait_idle();
      issue(3'd3, 32'hFFFFFFF9, 32'd2, 2'd0, 1'b0);  wait_idle();
      issue(3'd3, 32'h80000000, 32'hFFFFFFFF, 2'd0, 1'b0);  wait_idle();
      issue(3'd0, 32'h11111111, 32'd0, 2'd1, 1'b0);
      issue(3'd0, 32'h22222222, 32'd0, 2'd3, 1'b0);
      issue(3'd4, 32'h00000005, 32'd0, 2'd0, 1'b0);  wait_idle();
      cyc();
      chk("div0_hi", bus.HI, 32'h11111111);
      chk("div0_lo", bus.LO, 32'h22222222);

      // mthi while busy is ignored; the pending multiply still commits.
      issue(3'd1, 32'd7, 32'd9, 2'd0, 1'b0);
      bus.MD = 2'd1; bus.A = 32'h12345678;
      repeat (2) cyc();
      bus.MD = 2'd0;
      wait_idle();
      cyc();
      chk("busy_md_hi", bus.HI, 32'd0);
      issue(3'd0, 32'h12345678, 32'd0, 2'd1, 1'b1);
      issue(3'd0, 32'h12345678, 32'd0, 2'd1, 1'b0);
      chk("mthi_value", bus.HI, 32'h12345678);
      issue(3'd2, 32'd3, 32'd4, 2'd1, 1'b1);  // req blocks start too

      // Reset two cycles into a multiply discards it.
      issue(3'd1, 32'h00010000, 32'h00010000, 2'd0, 1'b0);
      cyc();
      reset = 1'b1;
      #1;
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_hi", bus.HI, 32'd0);
      chk("rst_lo", bus.LO, 32'd0);
      m_hi = 32'd0;
      m_lo = 32'd0;
      cyc();
      reset = 1'b0;
      repeat (8) cyc();
      chk("post_rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("post_rst_hi", bus.HI, 32'd0);
      chk("post_rst_lo", bus.LO, 32'd0);

      for (int i = 0; i < 60; i++) begin
         s = 3'($urandom_range(1, 4));
         if ($urandom_range(0, 7) == 0) s = 3'($urandom_range(0, 7));
         a = $urandom();
         case ($urandom_range(0, 7))
            0:       b = 32'd0;
            1:       b = 32'($urandom_range(1, 9));
            2:       b = 32'hFFFFFFFF;
            default: b = $urandom();
         endcase
         if ($urandom_range(0, 9) == 0) a = 32'h80000000;
         issue(s, a, b, 2'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0));
         wait_idle();
         repeat ($urandom_range(0, 2)) cyc();
      end

      repeat (3) cyc();
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
